// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_if
//  Description : Memory-mapped write/status port of the serial transmitter
//                plus the serial line itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if;
  logic        load;   // write strobe from the I/O decode
  logic [15:0] in;     // write data, only the low byte is transmitted
  logic [15:0] out;    // status word, bit 15 = busy
  logic        TX;     // serial line, idles high

  // CPU / bus side
  modport master (output load, output in, input out, input TX);
  // transmitter side
  modport slave  (input load, input in, output out, output TX);
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : 8N1 serial transmitter with a 16-bit memory-mapped write
//                port and a busy flag in status bit 15. All outputs are
//                registered; a write while busy is dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  wire logic  clk,
  input  wire logic  reset,
  uart_tx_if.slave   bus
);

  // Baud counter width: ceil(log2(CLKS_PER_BIT)), never below one bit.
  localparam int c_BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_BAUD_W-1:0] c_BAUD_MAX = c_BAUD_W'(CLKS_PER_BIT - 1);

  // Reject an unusable bit period at elaboration time.
  generate
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_param_check
      $error("uart_tx: CLKS_PER_BIT out of range 2..65535");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_BAUD_W-1:0] r_baud;
  logic [2:0]          r_bit;
  logic [7:0]          r_shift;
  logic                r_tx;
  logic                r_busy;

  // Last cycle of the current bit period.
  logic w_bit_done;
  assign w_bit_done = (r_baud == c_BAUD_MAX);

  // The upper write byte is deliberately ignored.
  logic w_unused_hi;
  assign w_unused_hi = ^bus.in[15:8];

  // Frame sequencer: IDLE -> START -> DATA x8 -> STOP, registered TX and busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          r_baud <= '0;
          r_bit  <= '0;
          if (bus.load) begin
            // Start bit goes out from the accepting edge onwards.
            r_shift <= bus.in[7:0];
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (w_bit_done) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_DATA: begin
          if (w_bit_done) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_tx    <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
              r_bit   <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_STOP: begin
          if (w_bit_done) begin
            // Busy falls here; a load on this same edge is still ignored.
            r_baud  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_baud  <= '0;
        end
      endcase
    end
  end

  assign bus.TX  = r_tx;
  assign bus.out = {r_busy, 15'h0000};

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx: a fast instance
//                (CLKS_PER_BIT=4) driven from a frame table plus directed
//                sequences, and a default-rate instance for bit timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  logic clk;
  logic reset;

  uart_tx_if if4 ();
  uart_tx_if if217 ();

  uart_tx #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4)
  );

  uart_tx u_dut217 (
    .clk   (clk),
    .reset (reset),
    .bus   (if217)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // frame[i] is the line level during bit period i (0 = start, 9 = stop).
  typedef struct {
    logic [15:0] din;
    logic [9:0]  frame;
    int          inj;      // cycle at which a second write is attempted, -1 none
    logic [15:0] inj_din;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at a negedge: the write is sampled at the following rising edge.
  task automatic start_frame(input logic [15:0] din);
    if4.load = 1'b1;
    if4.in   = din;
    @(posedge clk);
    #1 if4.load = 1'b0;
  endtask

  // Follows one 40-cycle frame on the fast instance; ends at a negedge
  // after the edge where busy falls.
  task automatic check_frame(input logic [9:0] exp, input int inj,
                             input logic [15:0] inj_din, input string nm);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      chk({nm, " tx"}, {15'h0, if4.TX}, {15'h0, exp[j/4]});
      chk({nm, " busy"}, if4.out, 16'h8000);
      if (j == inj) begin
        if4.load = 1'b1;
        if4.in   = inj_din;
      end else if (j == inj + 1) begin
        if4.load = 1'b0;
      end
    end
    @(negedge clk);
    chk({nm, " end out"}, if4.out, 16'h0000);
    chk({nm, " end tx"}, {15'h0, if4.TX}, 16'h0001);
    if4.load = 1'b0;
  endtask

  initial begin
    vecs[0] = '{din: 16'h0055, frame: 10'b1010101010, inj: -1, inj_din: 16'h0000};
    vecs[1] = '{din: 16'hFFA3, frame: 10'b1101000110, inj: -1, inj_din: 16'h0000};
    vecs[2] = '{din: 16'h0012, frame: 10'b1000100100, inj: 10, inj_din: 16'h00FF};
    vecs[3] = '{din: 16'h0081, frame: 10'b1100000010, inj: 39, inj_din: 16'h00FF};

    reset      = 1'b1;
    if4.load   = 1'b0;
    if4.in     = 16'h0000;
    if217.load = 1'b0;
    if217.in   = 16'h0000;

    // Reset held three cycles, then a long idle stretch.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset tx", {15'h0, if4.TX}, 16'h0001);
    chk("reset out", if4.out, 16'h0000);
    chk("reset tx217", {15'h0, if217.TX}, 16'h0001);
    chk("reset out217", if217.out, 16'h0000);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle tx", {15'h0, if4.TX}, 16'h0001);
      chk("idle out", if4.out, 16'h0000);
      chk("idle out217", if217.out, 16'h0000);
    end

    // Table of frames, each followed by an idle check.
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      start_frame(vecs[v].din);
      check_frame(vecs[v].frame, vecs[v].inj, vecs[v].inj_din, $sformatf("vec%0d", v));
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk($sformatf("vec%0d post tx", v), {15'h0, if4.TX}, 16'h0001);
        chk($sformatf("vec%0d post out", v), if4.out, 16'h0000);
      end
    end

    // Back-to-back: write on the first edge after busy falls.
    @(negedge clk);
    start_frame(16'h0012);
    check_frame(10'b1000100100, -1, 16'h0000, "b2b first");
    start_frame(16'h00FF);
    check_frame(10'b1111111110, -1, 16'h0000, "b2b second");

    // Reset in the middle of a 0x00 frame, then a clean 0x81 frame.
    @(negedge clk);
    start_frame(16'h0000);
    for (int j = 0; j < 17; j++) begin
      @(negedge clk);
      chk("abort pre tx", {15'h0, if4.TX}, 16'h0000);
      chk("abort pre out", if4.out, 16'h8000);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("abort tx", {15'h0, if4.TX}, 16'h0001);
    chk("abort out", if4.out, 16'h0000);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort idle tx", {15'h0, if4.TX}, 16'h0001);
      chk("abort idle out", if4.out, 16'h0000);
    end
    start_frame(16'h0081);
    check_frame(10'b1100000010, -1, 16'h0000, "after abort");

    // Default bit period: 0x41 frame, start-bit width and busy time.
    begin
      logic [9:0] exp41;
      int         low_cnt;
      int         busy_cnt;
      bit         seen_high;
      exp41     = 10'b1010000010;
      low_cnt   = 0;
      busy_cnt  = 0;
      seen_high = 1'b0;
      @(negedge clk);
      if217.load = 1'b1;
      if217.in   = 16'h0041;
      @(posedge clk);
      #1 if217.load = 1'b0;
      for (int j = 0; j < 3000; j++) begin
        @(negedge clk);
        if (!if217.out[15]) break;
        busy_cnt++;
        if (!seen_high && if217.TX == 1'b0) low_cnt++;
        else seen_high = 1'b1;
        if (j < 2170) chk("f217 tx", {15'h0, if217.TX}, {15'h0, exp41[j/217]});
      end
      chk("f217 start width", 16'(low_cnt), 16'd217);
      chk("f217 busy time", 16'(busy_cnt), 16'd2170);
      chk("f217 end out", if217.out, 16'h0000);
      chk("f217 end tx", {15'h0, if217.TX}, 16'h0001);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
